alu_md_decoder: RTL and testbench
=================================

Name: alu_md_decoder

Overview:
- Next-generation ALU decoder for the pipelined RISC-V core, sitting in the EX stage.
- Decodes the full RV32I/RV64I ALU operation set into a 4-bit ALUControl.
- Adds a parametrised iterative multiply/divide sequencer for the M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Stalls the pipeline while an M-op is in flight and delivers its result on completion.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- CTRL_W, 4, ALUControl width (must be ≥4).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- ALUOp  in  2  main-decoder ALU class.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- op  in  7  instruction opcode.
- Valid  in  1  EX stage holds a valid instruction.
- Flush  in  1  EX stage flush (branch mispredict/trap).
- SrcA  in  XLEN  ALU operand A (rs1).
- SrcB  in  XLEN  ALU operand B (rs2).
- ALUControl  out  CTRL_W  ALU operation select.
- MDSel  out  1  EX instruction is an M-op; EX result mux selects MDResult.
- MDResult  out  XLEN  M-op result; valid only while MDDone=1.
- MDDone  out  1  one-cycle result-valid pulse.
- Stall  out  1  hold IF/ID/EX; freeze EX operands.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high. On rst: state=IDLE, MDResult=0, MDDone=0, counter=0, internal operand/accumulator regs=0.
- ALUControl is combinational, zero-extended to CTRL_W:
  - ALUOp 00 → 0000 add.
  - ALUOp 01 → 0001 sub.
  - ALUOp 11 → 0000 add.
  - ALUOp 10, by funct3:
    - 000: sub (0001) if op[5]&funct7[5], else add (0000).
    - 001: sll 0111.
    - 010: slt 0101.
    - 011: sltu 0110.
    - 100: xor 0100.
    - 101: sra 1001 if funct7[5], else srl 1000.
    - 110: or 0011.
    - 111: and 0010.
- M-op detect: MOp = (ALUOp==10)&(op==0110011)&(funct7==0000001). When MOp: MDSel=1, ALUControl=1111. MDSel is combinational and independent of Valid.
- Start = Valid & MOp & ~Flush & (state==IDLE). funct3 selects the M operation.
- FSM: IDLE, BUSY, DONE.
  - IDLE→BUSY on Start. Latch operands, op type and sign flags. Convert signed operands to magnitudes: MUL/MULH/DIV/REM both signed; MULHSU A only; MULHU/DIVU/REMU none. Counter=XLEN.
  - IDLE→DONE directly on Start for DIV/DIVU/REM/REMU with SrcB=0:
    - quotient = all ones; remainder = SrcA.
    - For signed overflow (DIV/REM with SrcA=100..0, SrcB=all ones): quotient = SrcA, remainder = 0.
  - BUSY: one iteration per cycle, counter decrements.
    - Multiply: shift-add into a 2·XLEN product.
    - Divide: restoring, one quotient bit per cycle.
    - When counter reaches 1 → DONE.
  - DONE: apply sign fixup (negate the 2·XLEN product if signs differ; quotient sign = sA^sB; remainder sign = sA). Then drive MDResult:
    - MUL: product low half.
    - MULH/MULHSU/MULHU: product high half.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
    - MDDone=1 for exactly this cycle; next state IDLE. Start is ignored in DONE.
- Stall = (Valid & MOp & state==IDLE & ~Flush) | (state==BUSY). Stall=0 in DONE, so the pipeline advances with the result.
- Latency: normal M-op Stall high for XLEN+1 cycles (start cycle + XLEN BUSY); MDDone at cycle XLEN+1 relative to start cycle 0. Fast path (div-by-zero/overflow): Stall 1 cycle, MDDone at cycle 1.
- Back-to-back M-ops: second is accepted in the IDLE cycle after DONE.
- Flush in any state: state→IDLE next cycle, no MDDone, Stall=0 from the next cycle. Flush in the start cycle prevents the start.
- rst mid-operation: identical to reset; no MDDone.
- Outside DONE: MDResult holds its last value and MDDone=0.
- Operands are sampled only at Start; SrcA/SrcB changes during BUSY have no effect.

Test Plan:
- Decode sweep, all ALUOp/funct3/funct7[5]/op[5] combinations → ALUControl per table, e.g. ALUOp=10, f3=101, f7=0100000 → 1001. MOp with f3=000 → ALUControl=1111, MDSel=1.
- MUL SrcA=7, SrcB=0xFFFFFFFD (XLEN=32), Valid held while Stall → Stall cycles 0–32, MDDone at cycle 33, MDResult=0xFFFFFFEB. MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2, each done at cycle 33.
- DIVU 5/0 → MDDone at cycle 1, MDResult=0xFFFFFFFF; REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Flush asserted at cycle 10 of a DIV → IDLE at cycle 11, Stall=0 from cycle 11, no MDDone. rst at cycle 20 of a MUL → same, MDResult=0.
- Back-to-back MUL then DIVU → first MDDone at cycle 33, second accepted at cycle 34, second MDDone at cycle 34+33=67.

Source files
------------

// File: rtl/alu_md_decoder.sv
// alu_md_decoder: EX-stage ALU control decoder with an iterative RV32M/RV64M
// multiply/divide sequencer. Plain ALU ops decode combinationally; M-ops
// stall the pipeline until the sequencer returns a one-cycle MDDone pulse.
module alu_md_decoder #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [6:0]        op,
  input  logic              Valid,
  input  logic              Flush,
  input  logic [XLEN-1:0]   SrcA,
  input  logic [XLEN-1:0]   SrcB,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              MDSel,
  output logic [XLEN-1:0]   MDResult,
  output logic              MDDone,
  output logic              Stall
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   ZERO_X   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONES_X   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   MIN_X    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement negate of an XLEN value when neg is set.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? ((~v) + ONE_X) : v;
  endfunction

  // Two's-complement negate of a double-width product when neg is set.
  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? ((~v) + ONE_2X) : v;
  endfunction

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2*XLEN-1:0] acc_r;     // mul: {hi, multiplier/lo}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]   opnd_r;    // mul: multiplicand magnitude; div: divisor magnitude
  logic [2:0]        f3_r;
  logic              sa_r;
  logic              sb_r;

  logic [3:0]        ctrl_s;
  logic              mop_s;
  logic              start_s;
  logic              sgn_a_s;
  logic              sgn_b_s;
  logic              neg_a_s;
  logic              neg_b_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic              divz_s;
  logic              ovf_s;
  logic [XLEN-1:0]   fast_res_s;
  logic [XLEN:0]     hi_sum_s;
  logic [2*XLEN-1:0] mul_nxt_s;
  logic [XLEN:0]     shifted_s;
  logic              ge_s;
  logic [XLEN-1:0]   sub_s;
  logic [2*XLEN-1:0] div_nxt_s;
  logic [2*XLEN-1:0] acc_nxt_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   res_s;

  assign mop_s   = (ALUOp == 2'b10) && (op == 7'b0110011) && (funct7 == 7'b0000001);
  assign MDSel   = mop_s;
  assign start_s = Valid & mop_s & ~Flush & (state_r == IDLE);
  assign Stall   = start_s | (state_r == BUSY);

  // ALU operation decode; M-ops override with the M-unit select code.
  always_comb begin
    ctrl_s = 4'b0000;
    if (mop_s) begin
      ctrl_s = 4'b1111;
    end else begin
      case (ALUOp)
        2'b00: ctrl_s = 4'b0000;
        2'b01: ctrl_s = 4'b0001;
        2'b11: ctrl_s = 4'b0000;
        2'b10: begin
          case (funct3)
            3'b000: begin
              if (op[5] & funct7[5]) ctrl_s = 4'b0001;
              else                   ctrl_s = 4'b0000;
            end
            3'b001: ctrl_s = 4'b0111;
            3'b010: ctrl_s = 4'b0101;
            3'b011: ctrl_s = 4'b0110;
            3'b100: ctrl_s = 4'b0100;
            3'b101: begin
              if (funct7[5]) ctrl_s = 4'b1001;
              else           ctrl_s = 4'b1000;
            end
            3'b110: ctrl_s = 4'b0011;
            3'b111: ctrl_s = 4'b0010;
            default: ctrl_s = 4'b0000;
          endcase
        end
        default: ctrl_s = 4'b0000;
      endcase
    end
  end

  // Zero-extend the 4-bit code to the configured control width.
  always_comb begin
    ALUControl      = {CTRL_W{1'b0}};
    ALUControl[3:0] = ctrl_s;
  end

  // Operand signedness per M-op, magnitudes and the div fast-path result.
  always_comb begin
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
      3'b010:                         begin sgn_a_s = 1'b1; sgn_b_s = 1'b0; end
      default:                        begin sgn_a_s = 1'b0; sgn_b_s = 1'b0; end
    endcase
    neg_a_s = sgn_a_s & SrcA[XLEN-1];
    neg_b_s = sgn_b_s & SrcB[XLEN-1];
    mag_a_s = cond_neg(SrcA, neg_a_s);
    mag_b_s = cond_neg(SrcB, neg_b_s);
    divz_s  = funct3[2] & (SrcB == ZERO_X);
    ovf_s   = funct3[2] & ~funct3[0] & (SrcA == MIN_X) & (SrcB == ONES_X);
    if (divz_s) begin
      fast_res_s = funct3[1] ? SrcA : ONES_X;
    end else begin
      fast_res_s = funct3[1] ? ZERO_X : SrcA;
    end
  end

  // One shift-add or restoring-divide step, plus the sign-fixed final result.
  always_comb begin
    hi_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {1'b0, ZERO_X});
    mul_nxt_s = {hi_sum_s, acc_r[XLEN-1:1]};
    // Remainder shifted left with the next dividend bit brought in.
    shifted_s = acc_r[2*XLEN-1:XLEN-1];
    ge_s      = shifted_s >= {1'b0, opnd_r};
    sub_s     = shifted_s[XLEN-1:0] - opnd_r;
    if (ge_s) begin
      div_nxt_s = {sub_s, acc_r[XLEN-2:0], 1'b1};
    end else begin
      div_nxt_s = {shifted_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
    end
    acc_nxt_s = f3_r[2] ? div_nxt_s : mul_nxt_s;
    prod_s    = cond_neg2(acc_nxt_s, sa_r ^ sb_r);
    quo_s     = cond_neg(acc_nxt_s[XLEN-1:0], sa_r ^ sb_r);
    rem_s     = cond_neg(acc_nxt_s[2*XLEN-1:XLEN], sa_r);
    case (f3_r)
      3'b000:                 res_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_s = quo_s;
      3'b110, 3'b111:         res_s = rem_s;
      default:                res_s = ZERO_X;
    endcase
  end

  // Sequencer: accept an M-op, iterate XLEN steps, publish the result for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {(2*XLEN){1'b0}};
      opnd_r   <= ZERO_X;
      f3_r     <= 3'b000;
      sa_r     <= 1'b0;
      sb_r     <= 1'b0;
      MDResult <= ZERO_X;
      MDDone   <= 1'b0;
    end else if (Flush) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      MDDone  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          MDDone <= 1'b0;
          if (start_s) begin
            f3_r <= funct3;
            sa_r <= neg_a_s;
            sb_r <= neg_b_s;
            if (divz_s | ovf_s) begin
              state_r  <= DONE;
              MDResult <= fast_res_s;
              MDDone   <= 1'b1;
            end else begin
              state_r <= BUSY;
              cnt_r   <= CNT_INIT;
              if (funct3[2]) begin
                acc_r  <= {ZERO_X, mag_a_s};
                opnd_r <= mag_b_s;
              end else begin
                acc_r  <= {ZERO_X, mag_b_s};
                opnd_r <= mag_a_s;
              end
            end
          end
        end
        BUSY: begin
          acc_r <= acc_nxt_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r  <= DONE;
            MDResult <= res_s;
            MDDone   <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          MDDone  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          MDDone  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_decoder.sv
// Testbench for alu_md_decoder (XLEN=32): decode table sweep, directed and
// randomized M-ops against an arithmetic reference, flush/reset aborts.
module tb_alu_md_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [6:0]  op;
  logic        Valid;
  logic        Flush;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  ALUControl;
  logic        MDSel;
  logic [31:0] MDResult;
  logic        MDDone;
  logic        Stall;

  int checks = 0;
  int errors = 0;

  alu_md_decoder #(.XLEN(32), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst), .ALUOp(ALUOp), .funct3(funct3), .funct7(funct7),
    .op(op), .Valid(Valid), .Flush(Flush), .SrcA(SrcA), .SrcB(SrcB),
    .ALUControl(ALUControl), .MDSel(MDSel), .MDResult(MDResult),
    .MDDone(MDDone), .Stall(Stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // RISC-V M-extension result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 64'd0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic drive_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    ALUOp = 2'b10; op = 7'b0110011; funct7 = 7'b0000001; funct3 = f3;
    SrcA = a; SrcB = b; Valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; Valid = 1'b0; Flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (MDDone !== 1'b0) begin errors++; $display("FAIL reset_mddone got %b exp 0", MDDone); end
    checks++;
    if (MDResult !== 32'd0) begin errors++; $display("FAIL reset_mdresult got %h exp 0", MDResult); end
    checks++;
    if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", Stall); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_decode();
    int tab[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    logic [6:0] f7v[3] = '{7'b0000000, 7'b0100000, 7'b0000001};
    int exp;
    bit mop;
    Valid = 1'b0; Flush = 1'b0;
    for (int ao = 0; ao < 4; ao++)
      for (int f = 0; f < 8; f++)
        for (int s = 0; s < 3; s++)
          for (int o = 0; o < 2; o++) begin
            @(posedge clk); #1;
            ALUOp = 2'(ao); funct3 = 3'(f); funct7 = f7v[s];
            op = (o != 0) ? 7'b0110011 : 7'b0010011;
            mop = (ao == 2) && (o != 0) && (s == 2);
            if (mop) exp = 15;
            else if (ao == 1) exp = 1;
            else if (ao != 2) exp = 0;
            else if (f == 0) exp = ((o != 0) && (s == 1)) ? 1 : 0;
            else if (f == 5) exp = (s == 1) ? 9 : 8;
            else exp = tab[f];
            @(negedge clk);
            checks++;
            if (ALUControl !== 4'(exp)) begin
              errors++;
              $display("FAIL decode_ctrl aluop=%0d f3=%0d f7=%b op=%b got %b exp %b", ao, f, f7v[s], op, ALUControl, 4'(exp));
            end
            checks++;
            if (MDSel !== mop) begin errors++; $display("FAIL decode_mdsel got %b exp %b", MDSel, mop); end
            checks++;
            if (Stall !== 1'b0) begin errors++; $display("FAIL decode_stall got %b exp 0", Stall); end
          end
    @(posedge clk); #1;
  endtask

  // Runs one M-op with Valid held while stalled; leaves Valid high on return
  // (at the cycle after MDDone, where a following op may be accepted).
  task automatic run_mop(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int exp_lat, cyc, done_cyc, stalls;
    logic [31:0] got;
    bit fast;
    fast = f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    exp_lat = fast ? 1 : 33;
    drive_mop(f3, a, b);
    Flush = 1'b0;
    cyc = 0; done_cyc = -1; stalls = 0; got = 32'd0;
    while (done_cyc < 0 && cyc < 100) begin
      @(negedge clk);
      if (Stall) stalls++;
      if (MDDone) begin done_cyc = cyc; got = MDResult; end
      @(posedge clk); #1;
      cyc++;
      if (done_cyc < 0) begin SrcA = $urandom; SrcB = $urandom; end
    end
    checks++;
    if (done_cyc != exp_lat) begin errors++; $display("FAIL %s done_cycle got %0d exp %0d", name, done_cyc, exp_lat); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL %s result f3=%0d a=%h b=%h got %h exp %h", name, f3, a, b, got, exp); end
    checks++;
    if (stalls != exp_lat) begin errors++; $display("FAIL %s stall_cycles got %0d exp %0d", name, stalls, exp_lat); end
  endtask

  task automatic test_mul();
    run_mop("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    run_mop("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
    run_mop("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_mop("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    Valid = 1'b0;
  endtask

  task automatic test_div();
    run_mop("div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_mop("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_mop("divu", 3'd5, 32'd100, 32'd7, 32'd14);
    run_mop("remu", 3'd7, 32'd100, 32'd7, 32'd2);
    Valid = 1'b0;
  endtask

  task automatic test_fast_path();
    run_mop("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF);
    run_mop("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5);
    run_mop("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_mop("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    run_mop("rem_by0", 3'd6, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0);
    Valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_mop("b2b_mul", 3'd0, 32'd12345, 32'd678, 32'd8369910);
    run_mop("b2b_divu", 3'd5, 32'd1000, 32'd33, 32'd30);
    Valid = 1'b0;
  endtask

  // Aborts an M-op with Flush or rst during cycle 'at'.
  task automatic test_abort(input string name, input bit use_rst, input int at,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] pre;
    bit saw_done, stall_bad;
    pre = MDResult;
    saw_done = 1'b0; stall_bad = 1'b0;
    drive_mop(f3, a, b);
    Flush = 1'b0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (cyc == at) begin
        if (use_rst) rst = 1'b1;
        else Flush = 1'b1;
      end
      if (cyc == at + 1) begin rst = 1'b0; Flush = 1'b0; Valid = 1'b0; end
      @(negedge clk);
      if (MDDone) saw_done = 1'b1;
      if (Stall && ((cyc > at) || (cyc == 0 && at == 0 && !use_rst))) stall_bad = 1'b1;
      @(posedge clk); #1;
    end
    Valid = 1'b0;
    checks++;
    if (saw_done) begin errors++; $display("FAIL %s no_mddone got 1 exp 0", name); end
    checks++;
    if (stall_bad) begin errors++; $display("FAIL %s stall_after_abort got 1 exp 0", name); end
    checks++;
    if (MDResult !== (use_rst ? 32'd0 : pre)) begin
      errors++; $display("FAIL %s mdresult got %h exp %h", name, MDResult, use_rst ? 32'd0 : pre);
    end
  endtask

  task automatic test_aborts();
    test_abort("flush_div_c10", 1'b0, 10, 3'd4, 32'd1000, 32'd3);
    test_abort("flush_start", 1'b0, 0, 3'd0, 32'd9, 32'd9);
    test_abort("rst_mul_c20", 1'b1, 20, 3'd0, 32'd77, 32'd88);
    // sequencer still usable after aborts
    run_mop("post_abort_mul", 3'd0, 32'd3, 32'd5, 32'd15);
    Valid = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic [31:0] a, b;
    int mode;
    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      mode = $urandom_range(0, 5);
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (mode == 2) begin
        a = 32'($urandom_range(0, 500)); b = 32'($urandom_range(1, 20));
        if ($urandom_range(0, 1) != 0) a = -a;
        if ($urandom_range(0, 1) != 0) b = -b;
      end
      run_mop("rand", f3, a, b, ref_md(f3, a, b));
    end
    Valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; Valid = 1'b0; Flush = 1'b0;
    ALUOp = 2'b00; funct3 = 3'd0; funct7 = 7'd0; op = 7'd0;
    SrcA = 32'd0; SrcB = 32'd0;
    test_reset();
    test_decode();
    test_mul();
    test_div();
    test_fast_path();
    test_back_to_back();
    test_aborts();
    test_random();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
